mnist_frame_streamer: RTL and testbench



---
 rtl/mnist_pkg.sv | 24 ++
 rtl/pixel_bit_mux.sv | 19 +
 rtl/mnist_frame_streamer.sv | 108 ++++++++++
 tb/tb_mnist_frame_streamer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Shared constants and state encoding for the MNIST drawing/streaming/inference path.
package mnist_pkg;

   localparam int GRID_SIZE   = 28;
   localparam int NUM_PIXELS  = GRID_SIZE * GRID_SIZE;
   localparam int DATA_WIDTH  = 8;
   localparam int INDEX_WIDTH = 10;

   localparam logic [DATA_WIDTH-1:0]  ON_VALUE   = 8'd255;
   localparam logic [DATA_WIDTH-1:0]  OFF_VALUE  = 8'd0;
   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = 10'd783;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_STREAM = 2'b01,
      ST_DONE   = 2'b10
   } stream_state_e;

   // Map one bitmap bit onto the activation value fed to the network.
   function automatic logic [DATA_WIDTH-1:0] activation(input logic bit_i);
      return bit_i ? ON_VALUE : OFF_VALUE;
   endfunction

endpackage

// File: rtl/pixel_bit_mux.sv
// Wide bitmap-to-single-bit select, kept separate so it can be pipelined later.
module pixel_bit_mux
   import mnist_pkg::*;
(
   input  logic [NUM_PIXELS-1:0]  bits_i,
   input  logic [INDEX_WIDTH-1:0] sel_i,
   output logic                   bit_o
);

   // Select the addressed pixel; indices past the grid read as clear.
   always_comb begin
      if (sel_i <= LAST_INDEX) begin
         bit_o = bits_i[sel_i];
      end else begin
         bit_o = 1'b0;
      end
   end

endmodule

// File: rtl/mnist_frame_streamer.sv
// Snapshots the drawn bitmap on start and streams it pixel by pixel as
// activations over valid/ready, counting ink pixels along the way.
module mnist_frame_streamer
   import mnist_pkg::*;
(
   input  logic                   CLOCK_50,
   input  logic                   resetn,
   input  logic [NUM_PIXELS-1:0]  pixel_memory,
   input  logic                   start,
   input  logic                   abort,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [INDEX_WIDTH-1:0] out_index,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done,
   output logic [INDEX_WIDTH-1:0] ink_count
);

   stream_state_e            state_q, state_d;
   logic [NUM_PIXELS-1:0]    snapshot_q, snapshot_d;
   logic [INDEX_WIDTH-1:0]   index_q, index_d;
   logic [INDEX_WIDTH-1:0]   count_q, count_d;
   logic [INDEX_WIDTH-1:0]   ink_q, ink_d;
   logic                     pix_bit_s;
   logic                     at_last_s;

   pixel_bit_mux u_pixel_bit_mux (
      .bits_i (snapshot_q),
      .sel_i  (index_q),
      .bit_o  (pix_bit_s)
   );

   assign at_last_s = (index_q == LAST_INDEX);

   // Next-state logic: capture on start, advance on transfer, abort wins over a transfer.
   always_comb begin
      state_d    = state_q;
      snapshot_d = snapshot_q;
      index_d    = index_q;
      count_d    = count_q;
      ink_d      = ink_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               snapshot_d = pixel_memory;
               index_d    = {INDEX_WIDTH{1'b0}};
               count_d    = {INDEX_WIDTH{1'b0}};
               state_d    = ST_STREAM;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (out_ready) begin
               count_d = count_q + {{(INDEX_WIDTH-1){1'b0}}, pix_bit_s};
               if (at_last_s) begin
                  state_d = ST_DONE;
               end else begin
                  index_d = index_q + 10'd1;
               end
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_DONE: begin
            // The running count already includes the final beat here.
            ink_d   = count_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any frame in flight.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         snapshot_q <= {NUM_PIXELS{1'b0}};
         index_q    <= {INDEX_WIDTH{1'b0}};
         count_q    <= {INDEX_WIDTH{1'b0}};
         ink_q      <= {INDEX_WIDTH{1'b0}};
      end else begin
         state_q    <= state_d;
         snapshot_q <= snapshot_d;
         index_q    <= index_d;
         count_q    <= count_d;
         ink_q      <= ink_d;
      end
   end

   // Outputs decode registered state only, so they are glitch-free and hold during stalls.
   always_comb begin
      out_valid = (state_q == ST_STREAM);
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_DONE);
      out_data  = activation(pix_bit_s);
      out_index = index_q;
      out_last  = (state_q == ST_STREAM) && at_last_s;
      ink_count = ink_q;
   end

endmodule

// File: tb/tb_mnist_frame_streamer.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_mnist_frame_streamer;

   localparam int NP = 784;

   typedef struct packed {
      logic [7:0] data;
      logic [9:0] idx;
      logic       last;
   } beat_t;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [NP-1:0] pixel_memory = '0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          out_ready = 1'b1;
   logic          out_valid;
   logic [7:0]    out_data;
   logic [9:0]    out_index;
   logic          out_last;
   logic          busy;
   logic          done;
   logic [9:0]    ink_count;

   int    n_checks = 0;
   int    n_fail = 0;
   int    n_xfers = 0;
   beat_t sb[$];

   mnist_frame_streamer dut (
      .CLOCK_50     (clk),
      .resetn       (resetn),
      .pixel_memory (pixel_memory),
      .start        (start),
      .abort        (abort),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_index    (out_index),
      .out_last     (out_last),
      .busy         (busy),
      .done         (done),
      .ink_count    (ink_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [NP-1:0] bm);
      for (int i = 0; i < NP; i++) begin
         beat_t b;
         b.data = bm[i] ? 8'd255 : 8'd0;
         b.idx  = 10'(i);
         b.last = (i == NP - 1);
         sb.push_back(b);
      end
   endtask

   task automatic start_frame(input logic [NP-1:0] bm);
      pixel_memory = bm;
      push_frame(bm);
      chk("valid_before_start", {31'd0, out_valid}, 32'd0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("valid_latency1", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic run_until_idle(input bit rnd);
      for (int c = 0; c < 4000; c++) begin
         if (!busy) break;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         cyc();
      end
      out_ready = 1'b1;
      chk("frame_end_timeout", {31'd0, busy}, 32'd0);
   endtask

   // Monitor: pops expected beats on every transfer, checks stall stability and done timing.
   initial begin
      logic  prev_stall = 1'b0;
      logic  last_prev = 1'b0;
      beat_t held = '0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            prev_stall = 1'b0;
            last_prev  = 1'b0;
         end else begin
            logic xfer;
            if (done || last_prev) chk("done_pulse", {31'd0, done}, {31'd0, last_prev});
            if (prev_stall) begin
               chk("stall_valid", {31'd0, out_valid}, 32'd1);
               chk("stall_hold", {13'd0, out_data, out_index, out_last},
                   {13'd0, held.data, held.idx, held.last});
            end
            xfer = out_valid && out_ready && !abort;
            if (xfer) begin
               n_xfers++;
               if (sb.size() == 0) begin
                  chk("unexpected_beat_idx", {22'd0, out_index}, 32'd1023);
               end else begin
                  beat_t e;
                  e = sb.pop_front();
                  chk("beat_index", {22'd0, out_index}, {22'd0, e.idx});
                  chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
                  chk("beat_last", {31'd0, out_last}, {31'd0, e.last});
               end
            end
            last_prev  = xfer && out_last;
            prev_stall = out_valid && !out_ready && !abort;
            held.data  = out_data;
            held.idx   = out_index;
            held.last  = out_last;
         end
      end
   end

   // Directed stimulus sequence.
   initial begin
      logic [NP-1:0] bm_sparse;
      logic [NP-1:0] bm_four;
      logic [NP-1:0] bm_abort;
      int            x0;
      bm_sparse = '0;
      bm_sparse[0] = 1'b1;
      bm_sparse[29] = 1'b1;
      bm_sparse[783] = 1'b1;
      bm_four = bm_sparse;
      bm_four[500] = 1'b1;
      bm_abort = '0;
      bm_abort[50] = 1'b1;
      bm_abort[150] = 1'b1;

      // Reset state.
      #12;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ink", {22'd0, ink_count}, 32'd0);
      chk("rst_data", {24'd0, out_data}, 32'd0);
      chk("rst_index", {22'd0, out_index}, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);
      resetn = 1'b1;
      cyc();

      // Empty drawing.
      x0 = n_xfers;
      start_frame('0);
      run_until_idle(1'b0);
      chk("empty_ink", {22'd0, ink_count}, 32'd0);
      chk("empty_xfers", n_xfers - x0, 32'd784);

      // Sparse drawing, ready tied high.
      x0 = n_xfers;
      start_frame(bm_sparse);
      run_until_idle(1'b0);
      chk("sparse_ink", {22'd0, ink_count}, 32'd3);
      chk("sparse_xfers", n_xfers - x0, 32'd784);

      // Same drawing under random backpressure.
      x0 = n_xfers;
      start_frame(bm_sparse);
      run_until_idle(1'b1);
      chk("stall_ink", {22'd0, ink_count}, 32'd3);
      chk("stall_xfers", n_xfers - x0, 32'd784);

      // Bitmap changes mid-frame must not leak into the stream.
      x0 = n_xfers;
      start_frame(bm_four);
      for (int i = 0; i < 5; i++) cyc();
      pixel_memory = '1;
      run_until_idle(1'b0);
      chk("snapshot_ink", {22'd0, ink_count}, 32'd4);
      chk("snapshot_xfers", n_xfers - x0, 32'd784);

      // Abort at index 100.
      x0 = n_xfers;
      start_frame(bm_abort);
      for (int c = 0; c < 200; c++) begin
         if (out_index == 10'd100) break;
         cyc();
      end
      chk("abort_reach_idx", {22'd0, out_index}, 32'd100);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("abort_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_xfers", n_xfers - x0, 32'd100);
      sb.delete();
      for (int i = 0; i < 3; i++) cyc();
      chk("abort_ink_kept", {22'd0, ink_count}, 32'd4);
      x0 = n_xfers;
      start_frame(bm_abort);
      run_until_idle(1'b0);
      chk("after_abort_ink", {22'd0, ink_count}, 32'd2);
      chk("after_abort_xfers", n_xfers - x0, 32'd784);

      // Asynchronous reset mid-frame.
      start_frame(bm_sparse);
      for (int c = 0; c < 500; c++) begin
         if (out_index == 10'd400) break;
         cyc();
      end
      chk("rst_reach_idx", {22'd0, out_index}, 32'd400);
      resetn = 1'b0;
      #2;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_index", {22'd0, out_index}, 32'd0);
      chk("arst_ink", {22'd0, ink_count}, 32'd0);
      sb.delete();
      cyc();
      cyc();
      resetn = 1'b1;
      cyc();

      // A second start while busy must not restart the frame.
      x0 = n_xfers;
      start_frame(bm_sparse);
      for (int c = 0; c < 100; c++) begin
         if (out_index == 10'd50) break;
         cyc();
      end
      pixel_memory = '1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("restart_ignored_idx", {22'd0, out_index}, 32'd51);
      run_until_idle(1'b0);
      chk("restart_ignored_ink", {22'd0, ink_count}, 32'd3);
      chk("restart_ignored_xfers", n_xfers - x0, 32'd784);
      chk("sb_drained", sb.size(), 32'd0);

      cyc();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
